// File: rtl/uart_core.sv
// Full-duplex UART: valid/ready transmitter and 16x-oversampling receiver with
// configurable data width, optional parity and 1 or 2 stop bits.
module uart_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);
  localparam logic       ParEn    = (PARITY_EN != 0);
  localparam logic       ParOdd   = (PARITY_ODD != 0);

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [15:0]          tx_div_q, tx_div_d;
  logic [19:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_bit_end;

  always_comb begin
    // A bit lasts 16*(div+1) clk, so its last count is {div, 4'hF}.
    tx_bit_end = (tx_cnt_q == {tx_div_q, 4'hF});
    tx_ready   = (tx_state_q == TxIdle) ||
                 ((tx_state_q == TxStop) && (tx_bit_q == LastStop) && tx_bit_end);
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_bit_end ? 20'd0 : tx_cnt_q + 20'd1;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_d       = 1'b1;

    unique case (tx_state_q)
      TxIdle: tx_cnt_d = '0;
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LastData) begin
            tx_state_d = ParEn ? TxParity : TxStop;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shreg_d = tx_shreg_q >> 1;
          end
        end
      end
      TxParity: begin
        if (tx_bit_end) begin
          tx_state_d = TxStop;
          tx_bit_d   = '0;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LastStop) begin
            tx_state_d = TxIdle;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    if (tx_valid && tx_ready) begin
      tx_state_d = TxStart;
      tx_div_d   = baud_div;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shreg_d = tx_data;
      tx_par_d   = (^tx_data) ^ ParOdd;
    end

    // Line level is registered from the next state so tx is glitch-free.
    unique case (tx_state_d)
      TxStart:  tx_d = 1'b0;
      TxData:   tx_d = tx_shreg_d[0];
      TxParity: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_div_q   <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // ------------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [15:0]          presc_q, presc_d;
  logic [15:0]          rx_div_q, rx_div_d;
  logic [15:0]          rx_div_eff;
  logic                 rx_tick;
  logic [3:0]           rx_os_q, rx_os_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_perr_q, rx_perr_d;

  always_comb begin
    // Live divisor only between frames; >= keeps the prescaler sane if it shrinks.
    rx_div_eff = (rx_state_q == RxIdle) ? baud_div : rx_div_q;
    rx_tick    = (presc_q >= rx_div_eff);
    presc_d    = rx_tick ? 16'd0 : presc_q + 16'd1;
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = rx_ferr_q;
    rx_perr_d  = rx_perr_q;

    unique case (rx_state_q)
      RxIdle: begin
        if (rx_tick && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_os_d    = '0;
          rx_div_d   = baud_div;
        end
      end
      RxStart: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 4'd1;
          if (rx_os_q == 4'd7) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RxIdle : RxData;
          end
        end
      end
      RxData: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 4'd1;
          if (rx_os_q == 4'd15) begin
            rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
            if (rx_bit_q == LastData) begin
              rx_state_d = ParEn ? RxParity : RxStop;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end
        end
      end
      RxParity: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 4'd1;
          if (rx_os_q == 4'd15) begin
            rx_par_d   = rx_sync_q;
            rx_state_d = RxStop;
          end
        end
      end
      RxStop: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 4'd1;
          if (rx_os_q == 4'd15) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shreg_q;
            rx_ferr_d  = !rx_sync_q;
            rx_perr_d  = ParEn && (rx_par_q != ((^rx_shreg_q) ^ ParOdd));
            // Only the first stop bit is checked; a low line means a break.
            rx_state_d = rx_sync_q ? RxIdle : RxWaitHigh;
          end
        end
      end
      RxWaitHigh: begin
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      presc_q    <= '0;
      rx_state_q <= RxIdle;
      rx_div_q   <= '0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      presc_q    <= presc_d;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: three configurations (8N1, 7O2 loopback, 8E1 driven RX)
// checked against a frame-level model built from the serial framing rules.
module tb_uart_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // 8N1 instance
  logic [15:0] n_div = '0;
  logic        n_tx_valid = 1'b0;
  logic [7:0]  n_tx_data = '0;
  logic        n_tx_ready, n_tx;
  logic        n_rx = 1'b1;
  logic [7:0]  n_rx_data;
  logic        n_rx_valid, n_rx_ferr, n_rx_perr;

  uart_core #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .baud_div(n_div), .tx_valid(n_tx_valid), .tx_data(n_tx_data),
    .tx_ready(n_tx_ready), .tx(n_tx), .rx(n_rx), .rx_data(n_rx_data),
    .rx_valid(n_rx_valid), .rx_frame_err(n_rx_ferr), .rx_parity_err(n_rx_perr)
  );

  // 7 data bits, odd parity, 2 stop bits, tx looped back to rx
  logic [15:0] lb_div = 16'd3;
  logic        lb_tx_valid = 1'b0;
  logic [6:0]  lb_tx_data = '0;
  logic        lb_tx_ready, lb_tx;
  logic [6:0]  lb_rx_data;
  logic        lb_rx_valid, lb_rx_ferr, lb_rx_perr;

  uart_core #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_lb (
    .clk(clk), .rst(rst), .baud_div(lb_div), .tx_valid(lb_tx_valid), .tx_data(lb_tx_data),
    .tx_ready(lb_tx_ready), .tx(lb_tx), .rx(lb_tx), .rx_data(lb_rx_data),
    .rx_valid(lb_rx_valid), .rx_frame_err(lb_rx_ferr), .rx_parity_err(lb_rx_perr)
  );

  // 8E1 instance, receiver driven directly by the bench
  logic [15:0] e_div = 16'd2;
  logic        e_tx_ready, e_tx;
  logic        e_rx = 1'b1;
  logic [7:0]  e_rx_data;
  logic        e_rx_valid, e_rx_ferr, e_rx_perr;

  uart_core #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .baud_div(e_div), .tx_valid(1'b0), .tx_data(8'h00),
    .tx_ready(e_tx_ready), .tx(e_tx), .rx(e_rx), .rx_data(e_rx_data),
    .rx_valid(e_rx_valid), .rx_frame_err(e_rx_ferr), .rx_parity_err(e_rx_perr)
  );

  // Pulse monitors: count rx_valid pulses and capture the flags delivered with them
  int         n_pulses = 0, lb_pulses = 0, e_pulses = 0;
  logic [7:0] n_last_data = '0, e_last_data = '0;
  logic [6:0] lb_last_data = '0;
  logic       n_last_ferr = 0, n_last_perr = 0, lb_last_ferr = 0, lb_last_perr = 0;
  logic       e_last_ferr = 0, e_last_perr = 0;

  always @(posedge clk) begin
    if (n_rx_valid === 1'b1) begin
      n_pulses <= n_pulses + 1;
      n_last_data <= n_rx_data; n_last_ferr <= n_rx_ferr; n_last_perr <= n_rx_perr;
    end
    if (lb_rx_valid === 1'b1) begin
      lb_pulses <= lb_pulses + 1;
      lb_last_data <= lb_rx_data; lb_last_ferr <= lb_rx_ferr; lb_last_perr <= lb_rx_perr;
    end
    if (e_rx_valid === 1'b1) begin
      e_pulses <= e_pulses + 1;
      e_last_data <= e_rx_data; e_last_ferr <= e_rx_ferr; e_last_perr <= e_rx_perr;
    end
  end

  // Reference frame: bit 0 is the start bit; returns the number of bits on the line.
  function automatic int build_frame(input logic [8:0] data, input int nb, input int pe,
                                     input int po, input int sb, input bit flip_par,
                                     input bit bad_stop, output logic [15:0] f);
    int n;
    logic [8:0] mask;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      f[n] = data[i];
      n++;
    end
    if (pe != 0) begin
      mask = (9'd1 << nb) - 9'd1;
      f[n] = 1'(($countones(data & mask) + po) % 2) ^ flip_par;
      n++;
    end
    for (int s = 0; s < sb; s++) begin
      f[n] = (s == 0 && bad_stop) ? 1'b0 : 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic drive_e_bits(input logic [15:0] f, input int len, input int div);
    for (int b = 0; b < len; b++) begin
      e_rx = f[b];
      repeat (16 * (div + 1)) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_n_bits(input logic [15:0] f, input int len, input int div);
    for (int b = 0; b < len; b++) begin
      n_rx = f[b];
      repeat (16 * (div + 1)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (n_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got %b want 1", n_tx); end
    tests_run++;
    if (n_tx_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_tx_ready got %b want 1", n_tx_ready);
    end
    tests_run++;
    if (n_rx_valid !== 1'b0 || n_rx_ferr !== 1'b0 || n_rx_perr !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rx_flags got v=%b f=%b p=%b want 0", n_rx_valid, n_rx_ferr, n_rx_perr);
    end
    tests_run++;
    if (n_rx_data !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rx_data got %h want 00", n_rx_data);
    end
    tests_run++;
    if (lb_tx !== 1'b1 || lb_tx_ready !== 1'b1 || lb_rx_valid !== 1'b0 || lb_rx_data !== 7'h0 ||
        e_rx_valid !== 1'b0 || e_rx_perr !== 1'b0 || e_rx_ferr !== 1'b0 || e_rx_data !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_other got lb_tx=%b rdy=%b v=%b d=%h e_v=%b d=%h want idle/zero",
               lb_tx, lb_tx_ready, lb_rx_valid, lb_rx_data, e_rx_valid, e_rx_data);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_tx_frames();
    logic [7:0]  data;
    logic [15:0] f;
    int div, len, bitlen, total, bad_k;
    logic bad_tx, bad_rdy;
    for (int fr = 0; fr < 5; fr++) begin
      data = (fr == 0) ? 8'hA5 : 8'($urandom);
      div  = (fr == 0) ? 0 : int'($urandom_range(0, 3));
      len = build_frame({1'b0, data}, 8, 0, 0, 1, 1'b0, 1'b0, f);
      bitlen = 16 * (div + 1);
      total = len * bitlen;
      n_div = 16'(div);
      n_tx_data = data;
      n_tx_valid = 1'b1;
      tests_run++;
      if (n_tx_ready !== 1'b1) begin
        tests_failed++; $display("FAIL tx_ready_before_send got %b want 1", n_tx_ready);
      end
      @(posedge clk);
      #1;
      n_tx_valid = 1'b0;
      bad_k = -1;
      bad_tx = 1'b0;
      bad_rdy = 1'b0;
      for (int k = 0; k < total; k++) begin
        // Requests while busy and divisor changes mid-frame must not disturb the frame
        if (k == total / 2) begin
          n_tx_valid = 1'b1;
          n_tx_data = 8'($urandom);
          n_div = 16'($urandom_range(0, 7));
        end else if (k == total / 2 + 1) begin
          n_tx_valid = 1'b0;
        end
        if (bad_k < 0 && (n_tx !== f[k / bitlen] || n_tx_ready !== (k == total - 1))) begin
          bad_k = k; bad_tx = n_tx; bad_rdy = n_tx_ready;
        end
        @(posedge clk);
        #1;
      end
      tests_run++;
      if (bad_k >= 0) begin
        tests_failed++;
        $display("FAIL tx_frame data=%h div=%0d cycle %0d got tx=%b rdy=%b want tx=%b rdy=%b",
                 data, div, bad_k, bad_tx, bad_rdy, f[bad_k / bitlen], (bad_k == total - 1));
      end
      tests_run++;
      if (n_tx !== 1'b1 || n_tx_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_idle_after got tx=%b rdy=%b want 1 1", n_tx, n_tx_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1, f2;
    int len1, acc, bad_k;
    logic exp_tx, bad_tx;
    len1 = build_frame(9'h055, 8, 0, 0, 1, 1'b0, 1'b0, f1);
    void'(build_frame(9'h00F, 8, 0, 0, 1, 1'b0, 1'b0, f2));
    n_div = 16'd0;
    n_tx_data = 8'h55;
    n_tx_valid = 1'b1;
    acc = 0;
    if (n_tx_ready === 1'b1) acc++;
    @(posedge clk);
    #1;
    n_tx_data = 8'h0F;
    bad_k = -1;
    bad_tx = 1'b0;
    for (int k = 0; k < 2 * len1 * 16; k++) begin
      if (k == 2 * len1 * 16 - 1) n_tx_valid = 1'b0;
      if (n_tx_valid === 1'b1 && n_tx_ready === 1'b1) acc++;
      exp_tx = (k < len1 * 16) ? f1[k / 16] : f2[(k - len1 * 16) / 16];
      if (bad_k < 0 && n_tx !== exp_tx) begin bad_k = k; bad_tx = n_tx; end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bad_k >= 0) begin
      tests_failed++;
      $display("FAIL b2b_stream cycle %0d got tx=%b want the other level", bad_k, bad_tx);
    end
    tests_run++;
    if (acc != 2) begin tests_failed++; $display("FAIL b2b_accepts got %0d want 2", acc); end
    tests_run++;
    if (n_tx !== 1'b1 || n_tx_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_idle got tx=%b rdy=%b want 1 1", n_tx, n_tx_ready);
    end
  endtask

  task automatic test_loopback();
    logic [6:0] data;
    int div, p0, wait_cyc;
    for (int fr = 0; fr < 4; fr++) begin
      data = (fr == 0) ? 7'h5A : 7'($urandom);
      div  = (fr == 0) ? 3 : int'($urandom_range(0, 3));
      lb_div = 16'(div);
      lb_tx_data = data;
      lb_tx_valid = 1'b1;
      p0 = lb_pulses;
      @(posedge clk);
      #1;
      lb_tx_valid = 1'b0;
      // 11-bit frame plus margin; the receiver finishes mid first stop bit
      wait_cyc = 13 * 16 * (div + 1);
      repeat (wait_cyc) @(posedge clk);
      #1;
      tests_run++;
      if (lb_pulses - p0 != 1) begin
        tests_failed++; $display("FAIL lb_pulses got %0d want 1", lb_pulses - p0);
      end
      tests_run++;
      if (lb_last_data !== data || lb_last_ferr !== 1'b0 || lb_last_perr !== 1'b0) begin
        tests_failed++;
        $display("FAIL lb_rx got d=%h f=%b p=%b want d=%h f=0 p=0",
                 lb_last_data, lb_last_ferr, lb_last_perr, data);
      end
      tests_run++;
      if (lb_rx_data !== data) begin
        tests_failed++; $display("FAIL lb_rx_data_held got %h want %h", lb_rx_data, data);
      end
    end
  endtask

  task automatic test_rx_errors();
    logic [15:0] f;
    logic [7:0]  data;
    int len, div, p0;
    // Flipped parity on 0x3C
    div = 2;
    e_div = 16'(div);
    len = build_frame(9'h03C, 8, 1, 0, 1, 1'b1, 1'b0, f);
    p0 = e_pulses;
    drive_e_bits(f, len, div);
    e_rx = 1'b1;
    repeat (2 * 16 * (div + 1)) @(posedge clk);
    #1;
    tests_run++;
    if (e_pulses - p0 != 1 || e_last_data !== 8'h3C || e_last_perr !== 1'b1 ||
        e_last_ferr !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_parity_err got n=%0d d=%h p=%b f=%b want n=1 d=3c p=1 f=0",
               e_pulses - p0, e_last_data, e_last_perr, e_last_ferr);
    end
    // Clean frames at random divisors
    for (int i = 0; i < 3; i++) begin
      data = 8'($urandom);
      div = int'($urandom_range(0, 3));
      e_div = 16'(div);
      repeat (4) @(posedge clk);
      #1;
      len = build_frame({1'b0, data}, 8, 1, 0, 1, 1'b0, 1'b0, f);
      p0 = e_pulses;
      drive_e_bits(f, len, div);
      repeat (2 * 16 * (div + 1)) @(posedge clk);
      #1;
      tests_run++;
      if (e_pulses - p0 != 1 || e_last_data !== data || e_last_perr !== 1'b0 ||
          e_last_ferr !== 1'b0) begin
        tests_failed++;
        $display("FAIL rx_clean got n=%0d d=%h p=%b f=%b want n=1 d=%h p=0 f=0",
                 e_pulses - p0, e_last_data, e_last_perr, e_last_ferr, data);
      end
    end
    // Low stop bit followed by a 40-bit break
    div = 2;
    e_div = 16'(div);
    data = 8'($urandom);
    len = build_frame({1'b0, data}, 8, 1, 0, 1, 1'b0, 1'b1, f);
    p0 = e_pulses;
    drive_e_bits(f, len, div);
    e_rx = 1'b0;
    repeat (40 * 16 * (div + 1)) @(posedge clk);
    #1;
    tests_run++;
    if (e_pulses - p0 != 1 || e_last_ferr !== 1'b1 || e_last_data !== data) begin
      tests_failed++;
      $display("FAIL rx_frame_err got n=%0d f=%b d=%h want n=1 f=1 d=%h",
               e_pulses - p0, e_last_ferr, e_last_data, data);
    end
    e_rx = 1'b1;
    repeat (3 * 16 * (div + 1)) @(posedge clk);
    #1;
    tests_run++;
    if (e_pulses - p0 != 1) begin
      tests_failed++; $display("FAIL rx_break_extra got %0d pulses want 1", e_pulses - p0);
    end
  endtask

  task automatic test_glitch_and_rx8n1();
    logic [15:0] f;
    logic [7:0]  data;
    int len, p0, glen;
    n_div = 16'd1;
    for (int i = 0; i < 4; i++) begin
      glen = (i == 0) ? 3 : int'($urandom_range(1, 3));
      p0 = n_pulses;
      n_rx = 1'b0;
      repeat (glen) @(posedge clk);
      #1;
      n_rx = 1'b1;
      repeat (3 * 32 + int'($urandom_range(0, 5))) @(posedge clk);
      #1;
      tests_run++;
      if (n_pulses - p0 != 0) begin
        tests_failed++;
        $display("FAIL rx_glitch len=%0d got %0d pulses want 0", glen, n_pulses - p0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      data = 8'($urandom);
      len = build_frame({1'b0, data}, 8, 0, 0, 1, 1'b0, 1'b0, f);
      p0 = n_pulses;
      drive_n_bits(f, len, 1);
      repeat (2 * 32) @(posedge clk);
      #1;
      tests_run++;
      if (n_pulses - p0 != 1 || n_last_data !== data || n_last_ferr !== 1'b0 ||
          n_last_perr !== 1'b0) begin
        tests_failed++;
        $display("FAIL rx_8n1 got n=%0d d=%h f=%b p=%b want n=1 d=%h f=0 p=0",
                 n_pulses - p0, n_last_data, n_last_ferr, n_last_perr, data);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    int div, total, p0;
    for (int i = 0; i < 2; i++) begin
      div = int'($urandom_range(0, 2));
      n_div = 16'(div);
      n_tx_data = 8'($urandom);
      n_tx_valid = 1'b1;
      @(posedge clk);
      #1;
      n_tx_valid = 1'b0;
      total = 10 * 16 * (div + 1);
      repeat (int'($urandom_range(5, total - 5))) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (n_tx !== 1'b1 || n_tx_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_reset_mid got tx=%b rdy=%b want 1 1", n_tx, n_tx_ready);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
    end
    // Abort a receive part-way: no pulse may follow
    e_div = 16'd1;
    void'(build_frame(9'h0A6, 8, 1, 0, 1, 1'b0, 1'b0, f));
    p0 = e_pulses;
    drive_e_bits(f, 6, 1);
    e_rx = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12 * 32) @(posedge clk);
    #1;
    tests_run++;
    if (e_pulses - p0 != 0) begin
      tests_failed++; $display("FAIL rx_reset_mid got %0d pulses want 0", e_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frames();
    test_back_to_back();
    test_loopback();
    test_rx_errors();
    test_glitch_and_rx8n1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
